matrix_max_tracker: RTL and testbench
=====================================

Name: matrix_max_tracker

Overview:
- Streaming reduction stage downstream of the 4-bit unsigned greater-than comparator datapath in the matrix multiplier.
- Consumes one frame of COUNT result elements (default: a 3x3 product, 9 elements) over a valid/ready handshake.
- Tracks the running maximum value and its element index within the frame.
- Presents the result to the next stage on a held valid/ready output handshake.

Parameters:
- WIDTH, 4, element width in bits; elements are unsigned.
- COUNT, 9, elements per frame; legal range 1..2**IDX_W.
- IDX_W, 4, index width in bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- clear  input  1  synchronous abort; returns the block to IDLE.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept an element.
- in_data  input  WIDTH  element value.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- max_val  output  WIDTH  maximum value of the frame.
- max_idx  output  IDX_W  index of that element (0-based).

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values:
  - state = IDLE, cnt = 0, max_val = 0, max_idx = 0.
  - out_valid = 0, in_ready = 1.
- Element acceptance: an element is accepted on a clock edge where in_valid && in_ready.
- Comparison: unsigned strict greater-than, in_data > max_val, using the same equation as the comparator stage.
- Ties keep the earlier index (default).
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On accept: max_val<=in_data, max_idx<=0, cnt<=1.
    - Next state: DONE if COUNT==1, else SCAN.
  - SCAN: in_ready=1, out_valid=0.
    - On accept: if in_data>max_val, then max_val<=in_data and max_idx<=cnt; cnt<=cnt+1.
    - When the accepted element has cnt==COUNT-1, next state is DONE.
    - Idle cycles (in_valid=0) hold all state.
  - DONE: in_ready=0, out_valid=1.
    - max_val and max_idx are held stable.
    - On out_ready=1: next state IDLE, cnt<=0. out_valid drops the following cycle.
- Latency: out_valid rises on the cycle after the final element is accepted.
- No back-to-back overlap: the next frame's first element is accepted no earlier than the cycle after the result handshake.
- in_ready and out_valid are registered-state decodes only. No combinational path exists from in_valid or out_ready to outputs.
- clear=1: next state IDLE, cnt<=0, out_valid<=0. max_val and max_idx are retained but invalid. clear has priority over accept and over the result handshake in the same cycle.
- rst asserted mid-frame or in DONE: immediate return to reset values. The partial frame is discarded.
- cnt width is IDX_W+1 so that COUNT=2**IDX_W does not wrap.

Optional Feature:
- Macro: MAX_TRACKER_LAST_TIE_EN.
- Defined: the SCAN comparison becomes in_data >= max_val, so ties report the latest index. The IDLE first-element load is unchanged.
- Undefined: strict greater-than; ties report the earliest index.

Test Plan:
- Frame 3,7,2,9,9,1,0,5,4 with out_ready=1 -> out_valid one cycle after the 9th accept; max_val=9, max_idx=3. With MAX_TRACKER_LAST_TIE_EN defined -> max_idx=4.
- Frame of all 0 -> max_val=0, max_idx=0. Frame with 15 at index 8 -> max_val=15, max_idx=8.
- out_ready held 0 for 5 cycles in DONE -> out_valid and outputs stable, in_ready=0; in_valid pulses are ignored. Release -> IDLE next cycle and the new frame is accepted.
- in_valid gapped (1,0,0,1,...) across the frame 1,2,...,9 -> result max_val=9, max_idx=8, with no extra elements counted.
- clear asserted after the 4th element -> IDLE with out_valid=0. The following full frame 8,1,... produces a correct independent result.
- rst pulsed asynchronously between clock edges in SCAN -> outputs go to reset values immediately. After release, frame 5,5,5,... gives max_val=5, max_idx=0.

Source files
------------

// File: rtl/matrix_max_tracker.sv
// ============================================================================
// Module   : matrix_max_tracker
// Purpose  : Streaming arg-max over one COUNT-element frame with held result
//            handshake. Optional macro MAX_TRACKER_LAST_TIE_EN: ties report
//            the latest index instead of the earliest.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_max_tracker #(
   parameter int WIDTH = 4,
   parameter int COUNT = 9,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] max_val,
   output logic [IDX_W-1:0] max_idx
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [IDX_W:0] c_cnt_last = (IDX_W+1)'(COUNT - 1);
   localparam logic [IDX_W:0] c_cnt_one  = (IDX_W+1)'(1);
   localparam bit             c_single   = (COUNT == 1);

   state_t           r_state, w_state_nxt;
   logic [IDX_W:0]   r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] r_max_val, w_max_val_nxt;
   logic [IDX_W-1:0] r_max_idx, w_max_idx_nxt;
   logic             w_accept;
   logic             w_better;

   // Handshake outputs decode registered state only.
   assign in_ready  = (r_state != S_DONE);
   assign out_valid = (r_state == S_DONE);
   assign max_val   = r_max_val;
   assign max_idx   = r_max_idx;

   assign w_accept = in_valid && in_ready;

`ifdef MAX_TRACKER_LAST_TIE_EN
   assign w_better = (in_data >= r_max_val);
`else
   assign w_better = (in_data > r_max_val);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_max_val <= '0;
         r_max_idx <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_max_val <= w_max_val_nxt;
         r_max_idx <= w_max_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_max_val_nxt = r_max_val;
      w_max_idx_nxt = r_max_idx;
      // clear wins over both accept and the result handshake.
      if (clear) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  w_max_val_nxt = in_data;
                  w_max_idx_nxt = '0;
                  w_cnt_nxt     = c_cnt_one;
                  w_state_nxt   = c_single ? S_DONE : S_SCAN;
               end
            end
            S_SCAN: begin
               if (w_accept) begin
                  if (w_better) begin
                     w_max_val_nxt = in_data;
                     w_max_idx_nxt = r_cnt[IDX_W-1:0];
                  end
                  w_cnt_nxt = r_cnt + c_cnt_one;
                  if (r_cnt == c_cnt_last) begin
                     w_state_nxt = S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_matrix_max_tracker.sv
// ============================================================================
// Module   : tb_matrix_max_tracker
// Purpose  : Self-checking bench for matrix_max_tracker against a frame-level
//            arg-max reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_max_tracker;

   localparam int WIDTH = 4;
   localparam int COUNT = 9;
   localparam int IDX_W = 4;

`ifdef MAX_TRACKER_LAST_TIE_EN
   localparam bit c_last_tie = 1'b1;
`else
   localparam bit c_last_tie = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] max_val;
   logic [IDX_W-1:0] max_idx;

   int n_checks = 0;
   int n_fail   = 0;

   matrix_max_tracker #(.WIDTH(WIDTH), .COUNT(COUNT), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .max_val   (max_val),
      .max_idx   (max_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: elements collected so far and whether a result is held.
   int m_frame[$];
   bit m_hold = 1'b0;
   int m_val  = 0;
   int m_idx  = 0;

   // Outputs are compared mid-cycle, then the model consumes the inputs the
   // DUT will sample on the coming rising edge.
   always @(negedge clk) begin
      if (rst) begin
         m_frame.delete();
         m_hold = 1'b0;
      end else begin
         check("in_ready", int'(in_ready), int'(!m_hold));
         check("out_valid", int'(out_valid), int'(m_hold));
         if (m_hold) begin
            check("max_val", int'(max_val), m_val);
            check("max_idx", int'(max_idx), m_idx);
         end
         if (clear) begin
            m_frame.delete();
            m_hold = 1'b0;
         end else if (m_hold) begin
            if (out_ready) begin
               m_hold = 1'b0;
               m_frame.delete();
            end
         end else if (in_valid) begin
            m_frame.push_back(int'(in_data));
            if (m_frame.size() == COUNT) begin
               m_val = m_frame[0];
               m_idx = 0;
               for (int i = 1; i < COUNT; i++) begin
                  if (m_frame[i] > m_val || (c_last_tie && m_frame[i] == m_val)) begin
                     m_val = m_frame[i];
                     m_idx = i;
                  end
               end
               m_hold = 1'b1;
            end
         end
      end
   end

   task automatic cyc(input bit v, input int d, input bit ordy, input bit clr);
      in_valid  = v;
      in_data   = WIDTH'(d);
      out_ready = ordy;
      clear     = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int f[COUNT], input int gap, input bit ordy);
      for (int i = 0; i < COUNT; i++) begin
         cyc(1'b1, f[i], ordy, 1'b0);
         if (i != COUNT - 1) repeat (gap) cyc(1'b0, 0, ordy, 1'b0);
      end
   endtask

   task automatic expect_result(input string tag, input int v, input int idx);
      check({tag, "_valid"}, int'(out_valid), 1);
      check({tag, "_val"}, int'(max_val), v);
      check({tag, "_idx"}, int'(max_idx), idx);
   endtask

   int f_main[COUNT] = '{3, 7, 2, 9, 9, 1, 0, 5, 4};
   int f_zero[COUNT] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
   int f_top [COUNT] = '{1, 14, 3, 14, 0, 7, 2, 9, 15};
   int f_ramp[COUNT] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
   int f_clr [COUNT] = '{8, 1, 2, 3, 4, 5, 6, 7, 0};
   int f_five[COUNT] = '{5, 5, 5, 5, 5, 5, 5, 5, 5};

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_max_val", int'(max_val), 0);
      check("rst_max_idx", int'(max_idx), 0);
      rst = 1'b0;
      cyc(1'b0, 0, 1'b0, 1'b0);

      // Result visible on the cycle right after the ninth accept.
      send(f_main, 0, 1'b1);
      expect_result("main", 9, c_last_tie ? 4 : 3);
      cyc(1'b0, 0, 1'b1, 1'b0);
      check("main_drop", int'(out_valid), 0);

      send(f_zero, 0, 1'b1);
      expect_result("zero", 0, c_last_tie ? 8 : 0);
      cyc(1'b0, 0, 1'b1, 1'b0);

      send(f_top, 0, 1'b1);
      expect_result("top", 15, 8);
      cyc(1'b0, 0, 1'b1, 1'b0);

      // Back-pressure in DONE: outputs hold and element offers are ignored.
      send(f_main, 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(i[0], 15, 1'b0, 1'b0);
         check("hold_in_ready", int'(in_ready), 0);
         expect_result("hold", 9, c_last_tie ? 4 : 3);
      end
      cyc(1'b1, 15, 1'b1, 1'b0);
      check("release_valid", int'(out_valid), 0);
      check("release_in_ready", int'(in_ready), 1);
      send(f_ramp, 0, 1'b1);
      expect_result("after_release", 9, 8);
      cyc(1'b0, 0, 1'b1, 1'b0);

      send(f_ramp, 2, 1'b1);
      expect_result("gapped", 9, 8);
      cyc(1'b0, 0, 1'b1, 1'b0);

      // Abort after four elements; clear also beats a simultaneous offer.
      for (int i = 0; i < 4; i++) cyc(1'b1, 15, 1'b1, 1'b0);
      cyc(1'b1, 15, 1'b1, 1'b1);
      check("clear_valid", int'(out_valid), 0);
      check("clear_in_ready", int'(in_ready), 1);
      send(f_clr, 0, 1'b1);
      expect_result("post_clear", 8, 0);
      cyc(1'b0, 0, 1'b1, 1'b0);

      // Asynchronous reset between edges during a partial frame.
      for (int i = 0; i < 3; i++) cyc(1'b1, 12, 1'b1, 1'b0);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_in_ready", int'(in_ready), 1);
      check("arst_out_valid", int'(out_valid), 0);
      check("arst_max_val", int'(max_val), 0);
      check("arst_max_idx", int'(max_idx), 0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(f_five, 0, 1'b1);
      expect_result("five", 5, c_last_tie ? 8 : 0);
      cyc(1'b0, 0, 1'b1, 1'b0);

      // Random traffic with frequent ties, back-pressure and rare clears.
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 9) < 7,
             ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(6, 8),
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 59) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
